// File: rtl/sd_dev_cmd_phy.sv
// Card-side SD CMD line engine: receives 48-bit host commands and returns R1/R3/R6/R7 or R2
// responses after the Ncr gap. Optional receive CRC check: define SD_DEV_CMD_CRC_CHECK_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | line released, waiting for a host start bit
// RX       | shifting in the remaining 47 command bits
// WAIT_RSP | command accepted, Ncr counting, response request pending
// TX       | card drives CMD: one preamble cycle, then the response frame
module sd_dev_cmd_phy #(
   parameter int NCR = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_sd_cmd_in,
   output logic         o_sd_cmd_out,
   output logic         o_sd_cmd_dir,
   output logic         o_cmd_stb,
   output logic [5:0]   o_cmd_index,
   output logic [31:0]  o_cmd_arg,
   output logic         o_frame_err,
   output logic         o_crc_err,
   output logic         o_busy,
   input  logic         i_rsp_stb,
   input  logic         i_rsp_none,
   input  logic         i_rsp_long,
   input  logic [5:0]   i_rsp_index,
   input  logic [31:0]  i_rsp_arg,
   input  logic [127:0] i_rsp_data
);
   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_RX       = 2'd1;
   localparam logic [1:0] S_WAIT_RSP = 2'd2;
   localparam logic [1:0] S_TX       = 2'd3;

   localparam logic [6:0] NCR_SAT    = 7'(NCR);
   localparam logic [6:0] NCR_M1     = 7'(NCR - 1);
   localparam logic [5:0] RX_BITS_M1 = 6'd46;
   localparam logic [7:0] LEN_SHORT  = 8'd48;
   localparam logic [7:0] LEN_LONG   = 8'd136;

   function automatic logic [6:0] crc7_40(input logic [39:0] bits);
      logic [6:0] crc;
      logic       fb;
      crc = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         fb  = bits[i] ^ crc[6];
         crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return crc;
   endfunction

   logic [1:0]   state_q, state_d;
   logic [45:0]  rx_sh_q, rx_sh_d;
   logic [5:0]   bit_cnt_q, bit_cnt_d;
   logic [5:0]   cmd_index_q, cmd_index_d;
   logic [31:0]  cmd_arg_q, cmd_arg_d;
   logic         stb_q, stb_d;
   logic         frame_err_q, frame_err_d;
   logic         busy_q, busy_d;
   logic [6:0]   ncr_cnt_q, ncr_cnt_d;
   logic         pend_q, pend_d;
   logic [135:0] tx_sh_q, tx_sh_d;
   logic [7:0]   tx_cnt_q, tx_cnt_d;
   logic         cmd_out_q, cmd_out_d;
   logic         cmd_dir_q, cmd_dir_d;

   logic [39:0]  rsp_hdr;
   logic [135:0] rsp_frame;
   logic         rx_eval, rx_frame_bad, rx_crc_bad;
   logic         rsp_req, launch_ok;

   // R2 end bit overwrites data[0], which is never sent.
   assign rsp_hdr   = {2'b00, i_rsp_index, i_rsp_arg};
   assign rsp_frame = i_rsp_long ? ({2'b00, 6'h3f, i_rsp_data} | 136'd1)
                                 : {rsp_hdr, crc7_40(rsp_hdr), 1'b1, 88'd0};

   // rx_sh_q[45] holds the transmission bit; the end bit is still on the line at evaluation.
   assign rx_eval      = (state_q == S_RX) && (bit_cnt_q == 6'd0);
   assign rx_frame_bad = !rx_sh_q[45] || !i_sd_cmd_in;
   assign rsp_req      = i_rsp_stb && !i_rsp_none;
   assign launch_ok    = (ncr_cnt_q + 7'd1) >= NCR_M1;

`ifdef SD_DEV_CMD_CRC_CHECK_EN
   logic crc_err_q, crc_err_d;

   assign rx_crc_bad = crc7_40({1'b0, rx_sh_q[45:7]}) != rx_sh_q[6:0];
   assign crc_err_d  = rx_eval && !rx_frame_bad && rx_crc_bad;
   assign o_crc_err  = crc_err_q;

   always_ff @(posedge clk) begin
      if (rst) crc_err_q <= 1'b0;
      else     crc_err_q <= crc_err_d;
   end
`else
   assign rx_crc_bad = 1'b0;
   assign o_crc_err  = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      rx_sh_d     = rx_sh_q;
      bit_cnt_d   = bit_cnt_q;
      cmd_index_d = cmd_index_q;
      cmd_arg_d   = cmd_arg_q;
      stb_d       = 1'b0;
      frame_err_d = 1'b0;
      busy_d      = busy_q;
      ncr_cnt_d   = ncr_cnt_q;
      pend_d      = pend_q;
      tx_sh_d     = tx_sh_q;
      tx_cnt_d    = tx_cnt_q;
      cmd_out_d   = cmd_out_q;
      cmd_dir_d   = cmd_dir_q;
      case (state_q)
         S_IDLE: begin
            if (!i_sd_cmd_in) begin
               state_d   = S_RX;
               bit_cnt_d = RX_BITS_M1;
            end
         end
         S_RX: begin
            rx_sh_d   = {rx_sh_q[44:0], i_sd_cmd_in};
            bit_cnt_d = bit_cnt_q - 6'd1;
            if (rx_eval) begin
               if (rx_frame_bad) begin
                  frame_err_d = 1'b1;
                  state_d     = S_IDLE;
               end else if (rx_crc_bad) begin
                  state_d = S_IDLE;
               end else begin
                  stb_d       = 1'b1;
                  cmd_index_d = rx_sh_q[44:39];
                  cmd_arg_d   = rx_sh_q[38:7];
                  busy_d      = 1'b1;
                  ncr_cnt_d   = 7'd1;
                  pend_d      = 1'b0;
                  state_d     = S_WAIT_RSP;
               end
            end
         end
         S_WAIT_RSP: begin
            ncr_cnt_d = (ncr_cnt_q >= NCR_SAT) ? ncr_cnt_q : ncr_cnt_q + 7'd1;
            if (!i_sd_cmd_in) begin
               // host started a new command before our response went out
               busy_d    = 1'b0;
               pend_d    = 1'b0;
               bit_cnt_d = RX_BITS_M1;
               state_d   = S_RX;
            end else if (i_rsp_stb && i_rsp_none) begin
               busy_d  = 1'b0;
               pend_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               if (rsp_req) begin
                  tx_sh_d  = rsp_frame;
                  tx_cnt_d = i_rsp_long ? LEN_LONG : LEN_SHORT;
                  pend_d   = 1'b1;
               end
               if ((pend_q || rsp_req) && launch_ok) begin
                  cmd_dir_d = 1'b1;
                  cmd_out_d = 1'b1;
                  pend_d    = 1'b0;
                  state_d   = S_TX;
               end
            end
         end
         S_TX: begin
            if (tx_cnt_q == 8'd0) begin
               cmd_dir_d = 1'b0;
               cmd_out_d = 1'b1;
               busy_d    = 1'b0;
               state_d   = S_IDLE;
            end else begin
               cmd_out_d = tx_sh_q[135];
               tx_sh_d   = {tx_sh_q[134:0], 1'b0};
               tx_cnt_d  = tx_cnt_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rx_sh_q     <= '0;
         bit_cnt_q   <= '0;
         cmd_index_q <= '0;
         cmd_arg_q   <= '0;
         stb_q       <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         ncr_cnt_q   <= '0;
         pend_q      <= 1'b0;
         tx_sh_q     <= '0;
         tx_cnt_q    <= '0;
         cmd_out_q   <= 1'b1;
         cmd_dir_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rx_sh_q     <= rx_sh_d;
         bit_cnt_q   <= bit_cnt_d;
         cmd_index_q <= cmd_index_d;
         cmd_arg_q   <= cmd_arg_d;
         stb_q       <= stb_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
         ncr_cnt_q   <= ncr_cnt_d;
         pend_q      <= pend_d;
         tx_sh_q     <= tx_sh_d;
         tx_cnt_q    <= tx_cnt_d;
         cmd_out_q   <= cmd_out_d;
         cmd_dir_q   <= cmd_dir_d;
      end
   end

   assign o_sd_cmd_out = cmd_out_q;
   assign o_sd_cmd_dir = cmd_dir_q;
   assign o_cmd_stb    = stb_q;
   assign o_cmd_index  = cmd_index_q;
   assign o_cmd_arg    = cmd_arg_q;
   assign o_frame_err  = frame_err_q;
   assign o_busy       = busy_q;

endmodule

// File: tb/tb_sd_dev_cmd_phy.sv
// Scoreboard bench for sd_dev_cmd_phy: host command driver, response capture monitor.
module tb_sd_dev_cmd_phy;
   localparam int NCR = 2;
   localparam logic [2:0] EV_STB = 3'b001;
   localparam logic [2:0] EV_FE  = 3'b010;
   localparam logic [2:0] EV_CE  = 3'b100;
   localparam int M_NONE = 0, M_SHORT = 1, M_LONG = 2, M_PEND = 3, M_CUT = 4;
`ifdef SD_DEV_CMD_CRC_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         i_sd_cmd_in = 1'b1;
   logic         o_sd_cmd_out, o_sd_cmd_dir, o_cmd_stb, o_frame_err, o_crc_err, o_busy;
   logic [5:0]   o_cmd_index;
   logic [31:0]  o_cmd_arg;
   logic         i_rsp_stb = 1'b0, i_rsp_none = 1'b0, i_rsp_long = 1'b0;
   logic [5:0]   i_rsp_index = '0;
   logic [31:0]  i_rsp_arg = '0;
   logic [127:0] i_rsp_data = '0;

   sd_dev_cmd_phy #(.NCR(NCR)) dut (
      .clk(clk), .rst(rst), .i_sd_cmd_in(i_sd_cmd_in),
      .o_sd_cmd_out(o_sd_cmd_out), .o_sd_cmd_dir(o_sd_cmd_dir),
      .o_cmd_stb(o_cmd_stb), .o_cmd_index(o_cmd_index), .o_cmd_arg(o_cmd_arg),
      .o_frame_err(o_frame_err), .o_crc_err(o_crc_err), .o_busy(o_busy),
      .i_rsp_stb(i_rsp_stb), .i_rsp_none(i_rsp_none), .i_rsp_long(i_rsp_long),
      .i_rsp_index(i_rsp_index), .i_rsp_arg(i_rsp_arg), .i_rsp_data(i_rsp_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  kind;
      logic [5:0]  idx;
      logic [31:0] arg;
      int          cyc;
   } cmd_exp_t;

   typedef struct packed {
      logic [135:0] bits;
      int           len;
      int           start;
      logic         cut;
   } rsp_exp_t;

   cmd_exp_t cmd_q[$];
   rsp_exp_t rsp_q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] tb_crc7(input logic [39:0] d);
      logic [6:0] c;
      c = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         if (d[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'b0001001;
         else             c = {c[5:0], 1'b0};
      end
      return c;
   endfunction

   function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] h;
      h = {2'b01, idx, arg};
      return {h, tb_crc7(h), 1'b1};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: command events and CMD-line response capture
   logic         in_tx = 1'b0;
   logic         pre_bit = 1'b0;
   int           pre_cyc = 0;
   int           nb = 0;
   logic [135:0] cap = '0;

   always @(negedge clk) begin
      cmd_exp_t ce;
      rsp_exp_t re;
      if (o_cmd_stb || o_frame_err || o_crc_err) begin
         if (cmd_q.size() == 0)
            chk("unexpected_cmd_event", 136'({o_crc_err, o_frame_err, o_cmd_stb}), 136'd0);
         else begin
            ce = cmd_q.pop_front();
            chk("ev_kind", 136'({o_crc_err, o_frame_err, o_cmd_stb}), 136'(ce.kind));
            chk("ev_cycle", 136'(cyc), 136'(ce.cyc));
            if (ce.kind == EV_STB) begin
               chk("cmd_index", 136'(o_cmd_index), 136'(ce.idx));
               chk("cmd_arg", 136'(o_cmd_arg), 136'(ce.arg));
            end
         end
      end
      if (o_sd_cmd_dir) begin
         if (!in_tx) begin
            in_tx   = 1'b1;
            pre_cyc = cyc;
            pre_bit = o_sd_cmd_out;
            nb      = 0;
            cap     = '0;
         end else begin
            cap = {cap[134:0], o_sd_cmd_out};
            nb++;
         end
      end else if (in_tx) begin
         in_tx = 1'b0;
         if (rsp_q.size() == 0)
            chk("unexpected_response", 136'(nb + 1), 136'd0);
         else begin
            re = rsp_q.pop_front();
            chk("rsp_start_cycle", 136'(pre_cyc + 1), 136'(re.start));
            if (!re.cut) begin
               chk("rsp_preamble", 136'(pre_bit), 136'd1);
               chk("rsp_len", 136'(nb), 136'(re.len));
               chk("rsp_bits", cap, re.bits);
            end
         end
      end
   end

   task automatic wait_idle();
      for (int k = 0; k < 400; k++) begin
         if (!o_busy && !o_sd_cmd_dir) break;
         @(negedge clk);
      end
      chk("wait_idle", 136'({o_busy, o_sd_cmd_dir}), 136'd0);
   endtask

   task automatic run_cmd(input logic [47:0] frame, input int mode, input int dly,
                          input logic [5:0] ridx, input logic [31:0] rarg,
                          input logic [127:0] rdata, input bit abort_chk);
      cmd_exp_t    ce;
      rsp_exp_t    re;
      logic [39:0] h;
      int          end_cyc, r;
      ce.idx = frame[45:40];
      ce.arg = frame[39:8];
      ce.cyc = 0;
      if (!frame[46] || !frame[0])                       ce.kind = EV_FE;
      else if (CRC_EN && tb_crc7(frame[47:8]) != frame[7:1]) ce.kind = EV_CE;
      else                                                ce.kind = EV_STB;
      end_cyc = 0;
      for (int i = 47; i >= 0; i--) begin
         @(negedge clk);
         if (abort_chk && i == 46) chk("abort_busy_drop", 136'(o_busy), 136'd0);
         i_sd_cmd_in = frame[i];
         if (i == 0) begin
            end_cyc = cyc;
            ce.cyc  = cyc + 1;
            cmd_q.push_back(ce);
         end
      end
      @(negedge clk);
      i_sd_cmd_in = 1'b1;
      if (ce.kind != EV_STB) begin
         chk("busy_after_reject", 136'(o_busy), 136'd0);
         return;
      end
      chk("busy_at_stb", 136'(o_busy), 136'd1);
      if (mode == M_PEND) return;
      repeat (dly) @(negedge clk);
      r = cyc;
      i_rsp_stb   = 1'b1;
      i_rsp_none  = (mode == M_NONE);
      i_rsp_long  = (mode == M_LONG);
      i_rsp_index = ridx;
      i_rsp_arg   = rarg;
      i_rsp_data  = rdata;
      if (mode != M_NONE) begin
         if (mode == M_LONG) begin
            re.bits = {2'b00, 6'h3f, rdata[127:1], 1'b1};
            re.len  = 136;
         end else begin
            h       = {2'b00, ridx, rarg};
            re.bits = 136'({h, tb_crc7(h), 1'b1});
            re.len  = 48;
         end
         re.start = (end_cyc + NCR > r + 2) ? end_cyc + NCR : r + 2;
         re.cut   = (mode == M_CUT);
         rsp_q.push_back(re);
      end
      @(negedge clk);
      i_rsp_stb  = 1'b0;
      i_rsp_none = 1'b0;
      i_rsp_long = 1'b0;
      if (mode == M_NONE)     chk("busy_after_none", 136'(o_busy), 136'd0);
      else if (mode != M_CUT) wait_idle();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int found;
      repeat (3) @(negedge clk);
      chk("rst_dir", 136'(o_sd_cmd_dir), 136'd0);
      chk("rst_out", 136'(o_sd_cmd_out), 136'd1);
      chk("rst_stb", 136'(o_cmd_stb), 136'd0);
      chk("rst_ferr", 136'(o_frame_err), 136'd0);
      chk("rst_cerr", 136'(o_crc_err), 136'd0);
      chk("rst_busy", 136'(o_busy), 136'd0);
      chk("rst_index", 136'(o_cmd_index), 136'd0);
      chk("rst_arg", 136'(o_cmd_arg), 136'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // CMD0, no response
      run_cmd(48'h40_00000000_95, M_NONE, 0, '0, '0, '0, 1'b0);
      // CMD8 with R7-style short response requested at o_cmd_stb
      run_cmd(48'h48_000001AA_87, M_SHORT, 0, 6'd0, 32'd0, '0, 1'b0);
      // bad CRC, bad end bit, bad transmission bit
      run_cmd(48'h48_000001AA_89, M_NONE, 0, '0, '0, '0, 1'b0);
      run_cmd(48'h40_00000000_94, M_NONE, 0, '0, '0, '0, 1'b0);
      run_cmd(48'h00_00000000_95, M_NONE, 0, '0, '0, '0, 1'b0);
      // CMD2 with late R2
      run_cmd(make_cmd(6'd2, 32'd0), M_LONG, 5, '0, '0, {16{8'hA5}}, 1'b0);
      // random short commands and responses with varying latency
      for (int n = 0; n < 3; n++)
         run_cmd(make_cmd(6'($urandom_range(0, 63)), $urandom), M_SHORT, $urandom_range(0, 6),
                 6'($urandom_range(0, 63)), $urandom, '0, 1'b0);

      // new command aborts a pending response
      run_cmd(48'h40_00000000_95, M_PEND, 0, '0, '0, '0, 1'b0);
      repeat (3) @(negedge clk);
      run_cmd(make_cmd(6'd55, 32'h1234_0000), M_NONE, 0, '0, '0, '0, 1'b1);

      // reset during response bit 20
      run_cmd(make_cmd(6'd17, 32'h0000_0200), M_CUT, 0, 6'd17, 32'h0000_0900, '0, 1'b0);
      found = 0;
      for (int k = 0; k < 20; k++) begin
         if (o_sd_cmd_dir) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      chk("tx_started", 136'(found), 136'd1);
      repeat (21) @(negedge clk);
      chk("tx_bit20_driving", 136'(o_sd_cmd_dir), 136'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_dir", 136'(o_sd_cmd_dir), 136'd0);
      chk("rst_mid_out", 136'(o_sd_cmd_out), 136'd1);
      chk("rst_mid_busy", 136'(o_busy), 136'd0);
      rst = 1'b0;
      @(negedge clk);
      run_cmd(48'h40_00000000_95, M_NONE, 0, '0, '0, '0, 1'b0);

      // response request outside WAIT_RSP is ignored
      i_rsp_stb = 1'b1;
      @(negedge clk);
      i_rsp_stb = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_rsp_ignored_dir", 136'(o_sd_cmd_dir), 136'd0);
      chk("idle_rsp_ignored_busy", 136'(o_busy), 136'd0);

      repeat (5) @(negedge clk);
      chk("cmd_q_drained", 136'(cmd_q.size()), 136'd0);
      chk("rsp_q_drained", 136'(rsp_q.size()), 136'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
